// File: rtl/ac97_link_if.sv
// Slot-side bus of the AC-link engine: outbound slot data from producers and the
// published inbound frame, codec readiness and frame count for consumers.
interface ac97_link_if #(
    parameter int unsigned NUM_SLOTS = 12
);
    logic [20*NUM_SLOTS-1:0] out_slots;
    logic [NUM_SLOTS-1:0]    out_valid;
    logic [20*NUM_SLOTS-1:0] in_slots;
    logic [NUM_SLOTS-1:0]    in_valid;
    logic                    in_codec_ready;
    logic                    link_up;
    logic [15:0]             frame_cnt;

    modport master (
        output out_slots, out_valid,
        input  in_slots, in_valid, in_codec_ready, link_up, frame_cnt
    );

    modport slave (
        input  out_slots, out_valid,
        output in_slots, in_valid, in_codec_ready, link_up, frame_cnt
    );
endinterface

// File: rtl/ac97_link_engine.sv
// AC-link frame engine: serialises 256-bit outbound frames from a per-frame shadow,
// assembles inbound frames, drives SYNC/strobe and qualifies codec readiness.
module ac97_link_engine #(
    parameter int unsigned NUM_SLOTS     = 12,
    parameter int unsigned READY_FRAMES  = 4,
    parameter int unsigned GATE_ON_READY = 1
) (
    input  logic       ac97_bitclk,
    input  logic       ac97_rst,
    input  logic       ac97_sdata_in,
    output logic       ac97_sdata_out,
    output logic       ac97_sync,
    output logic       ac97_reset_b,
    output logic       ac97_strobe,
    ac97_link_if.slave bus
);
    localparam int unsigned DataW   = 20 * NUM_SLOTS;
    localparam logic [7:0]  RdyMax  = 8'(READY_FRAMES);

    logic [7:0]           bit_cnt_q, bit_cnt_d;
    logic [DataW-1:0]     shadow_slots_q, shadow_slots_d;
    logic [NUM_SLOTS-1:0] shadow_valid_q, shadow_valid_d;
    logic [255:0]         tx_frame;
    logic [255:0]         rx_asm_q;
    logic [DataW-1:0]     rx_slots, in_slots_q;
    logic [NUM_SLOTS-1:0] rx_valid, in_valid_q;
    logic                 in_ready_q;
    logic                 sdata_out_q, sync_q, strobe_q;
    logic                 primed_q, publish, gate_ok;
    logic [7:0]           rdy_cnt_q, rdy_cnt_d;
    logic                 link_up_q;
    logic [15:0]          frame_cnt_q;
    logic                 unused_rx_bits;

    always_comb begin
        bit_cnt_d      = bit_cnt_q + 8'd1;
        // The first 255->0 step after reset closes no received frame.
        publish        = primed_q && (bit_cnt_q == 8'd255);
        shadow_slots_d = (bit_cnt_q == 8'd0) ? bus.out_slots : shadow_slots_q;
        shadow_valid_d = (bit_cnt_q == 8'd0) ? bus.out_valid : shadow_valid_q;
        gate_ok        = (GATE_ON_READY == 0) || link_up_q;
        rdy_cnt_d      = rdy_cnt_q;
        if (publish) begin
            if (!rx_asm_q[0]) begin
                rdy_cnt_d = 8'd0;
            end else if (rdy_cnt_q != RdyMax) begin
                rdy_cnt_d = rdy_cnt_q + 8'd1;
            end
        end
    end

    // tx_frame and rx_asm_q are indexed by frame bit position (0 = tag bit 15).
    assign tx_frame[0]     = 1'b1;
    assign tx_frame[15:13] = 3'b000;

    for (genvar k = 0; k < 12; k++) begin : g_slot
        if (k < NUM_SLOTS) begin : g_on
            logic send;
            assign send             = shadow_valid_d[k] & gate_ok;
            assign tx_frame[1+k]    = send;
            assign rx_valid[k]      = rx_asm_q[1+k];
            for (genvar b = 0; b < 20; b++) begin : g_bit
                assign tx_frame[16+20*k+b]   = send & shadow_slots_d[20*k+19-b];
                assign rx_slots[20*k+19-b]   = rx_asm_q[16+20*k+b];
            end
        end else begin : g_off
            assign tx_frame[1+k]         = 1'b0;
            assign tx_frame[16+20*k +: 20] = 20'd0;
        end
    end

    assign unused_rx_bits = ^rx_asm_q;

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            bit_cnt_q      <= 8'hFF;
            primed_q       <= 1'b0;
            shadow_slots_q <= '0;
            shadow_valid_q <= '0;
            sdata_out_q    <= 1'b0;
            sync_q         <= 1'b0;
            strobe_q       <= 1'b0;
            in_slots_q     <= '0;
            in_valid_q     <= '0;
            in_ready_q     <= 1'b0;
            rdy_cnt_q      <= 8'd0;
            link_up_q      <= 1'b0;
            frame_cnt_q    <= 16'd0;
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            primed_q       <= 1'b1;
            shadow_slots_q <= shadow_slots_d;
            shadow_valid_q <= shadow_valid_d;
            sdata_out_q    <= tx_frame[bit_cnt_d];
            sync_q         <= (bit_cnt_d == 8'd255) || (bit_cnt_d < 8'd15);
            strobe_q       <= (bit_cnt_d == 8'd0);
            rdy_cnt_q      <= rdy_cnt_d;
            if (publish) begin
                in_slots_q  <= rx_slots;
                in_valid_q  <= rx_valid;
                in_ready_q  <= rx_asm_q[0];
                link_up_q   <= (rdy_cnt_d == RdyMax);
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Codec launches sdata_in on posedge; capture mid-bit.
    always_ff @(negedge ac97_bitclk) begin
        if (ac97_rst) begin
            rx_asm_q <= '0;
        end else begin
            rx_asm_q[bit_cnt_q] <= ac97_sdata_in;
        end
    end

    assign ac97_sdata_out     = sdata_out_q;
    assign ac97_sync          = sync_q;
    assign ac97_strobe        = strobe_q;
    assign ac97_reset_b       = ~ac97_rst;
    assign bus.in_slots       = in_slots_q;
    assign bus.in_valid       = in_valid_q;
    assign bus.in_codec_ready = in_ready_q;
    assign bus.link_up        = link_up_q;
    assign bus.frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_ac97_link_engine.sv
// Bench for ac97_link_engine: three instances (ungated, gated, 4-slot) share one codec
// stream; expected frames and publications are queued at stimulus time and checked on output.
module tb_ac97_link_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sdi;
    logic sdo_a, sync_a, rstb_a, stb_a;
    logic sdo_b, sync_b, rstb_b, stb_b;
    logic sdo_c, sync_c, rstb_c, stb_c;

    always #5 clk = ~clk;

    ac97_link_if #(.NUM_SLOTS(12)) ifa ();
    ac97_link_if #(.NUM_SLOTS(12)) ifb ();
    ac97_link_if #(.NUM_SLOTS(4))  ifc ();

    ac97_link_engine #(.NUM_SLOTS(12), .READY_FRAMES(4), .GATE_ON_READY(0)) dut_a (
        .ac97_bitclk(clk), .ac97_rst(rst), .ac97_sdata_in(sdi), .ac97_sdata_out(sdo_a),
        .ac97_sync(sync_a), .ac97_reset_b(rstb_a), .ac97_strobe(stb_a), .bus(ifa)
    );
    ac97_link_engine #(.NUM_SLOTS(12), .READY_FRAMES(4), .GATE_ON_READY(1)) dut_b (
        .ac97_bitclk(clk), .ac97_rst(rst), .ac97_sdata_in(sdi), .ac97_sdata_out(sdo_b),
        .ac97_sync(sync_b), .ac97_reset_b(rstb_b), .ac97_strobe(stb_b), .bus(ifb)
    );
    ac97_link_engine #(.NUM_SLOTS(4), .READY_FRAMES(4), .GATE_ON_READY(0)) dut_c (
        .ac97_bitclk(clk), .ac97_rst(rst), .ac97_sdata_in(sdi), .ac97_sdata_out(sdo_c),
        .ac97_sync(sync_c), .ac97_reset_b(rstb_c), .ac97_strobe(stb_c), .bus(ifc)
    );

    typedef struct {
        int           frame;
        logic [255:0] a, b, c;
    } tx_t;

    typedef struct {
        int           frame;
        logic [239:0] slots;
        logic [11:0]  valid;
        logic         rdy;
        logic         link;
        logic [15:0]  fcnt;
    } pub_t;

    localparam logic [255:0] SyncExp = {{15{1'b1}}, 240'd0, 1'b1};
    localparam logic [255:0] StbExp  = {1'b1, 255'd0};
    localparam logic [255:0] IdleTag = {1'b1, 255'd0};

    tx_t          tx_q[$];
    pub_t         pub_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           tb_pos = 255;
    int           tb_frame = 0;
    logic [255:0] rx_cur = '0;
    int           m_rdy = 0;
    logic         m_link = 1'b0;
    logic [15:0]  m_fcnt = '0;

    // Frames are held in transmission order: bit position p lives at index 255-p.
    assign sdi = rx_cur[255-tb_pos];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] frame_bits(input logic [11:0] v, input logic [239:0] s,
                                                input int ns, input logic tag15);
        logic [255:0] f;
        f = '0;
        f[255] = tag15;
        for (int k = 1; k <= ns; k++) begin
            f[255-k] = v[k-1];
            f[239-20*(k-1) -: 20] = s[20*(k-1) +: 20];
        end
        return f;
    endfunction

    function automatic logic [239:0] zero_invalid(input logic [11:0] v, input logic [239:0] s);
        logic [239:0] r;
        r = s;
        for (int k = 0; k < 12; k++) if (!v[k]) r[20*k +: 20] = '0;
        return r;
    endfunction

    function automatic logic [239:0] rnd240();
        logic [239:0] r;
        for (int k = 0; k < 8; k++) r[30*k +: 30] = 30'($urandom);
        return r;
    endfunction

    // Bit position reference, independent of the DUT.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            tb_pos <= 255;
        end else begin
            tb_pos <= (tb_pos + 1) % 256;
            if (tb_pos == 255) tb_frame <= tb_frame + 1;
        end
    end

    // Monitor: collect serial output per frame, compare frames and publications.
    initial begin
        logic [255:0] cap_a, cap_b, cap_c, cap_sync, cap_stb;
        tx_t  t;
        pub_t p;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cap_a[255-tb_pos]    = sdo_a;
                cap_b[255-tb_pos]    = sdo_b;
                cap_c[255-tb_pos]    = sdo_c;
                cap_sync[255-tb_pos] = sync_a;
                cap_stb[255-tb_pos]  = stb_a;
                if (tb_pos == 255 && tx_q.size() > 0 && tx_q[0].frame == tb_frame) begin
                    t = tx_q.pop_front();
                    chk("tx_frame_a", cap_a, t.a);
                    chk("tx_frame_b_gated", cap_b, t.b);
                    chk("tx_frame_c_4slot", cap_c, t.c);
                    chk("sync_pattern", cap_sync, SyncExp);
                    chk("strobe_pattern", cap_stb, StbExp);
                end
                if (tb_pos == 0 && pub_q.size() > 0 && pub_q[0].frame == tb_frame - 1) begin
                    p = pub_q.pop_front();
                    chk("in_slots_a", 256'(ifa.in_slots), 256'(p.slots));
                    chk("in_valid_a", 256'(ifa.in_valid), 256'(p.valid));
                    chk("in_codec_ready_a", 256'(ifa.in_codec_ready), 256'(p.rdy));
                    chk("link_up_a", 256'(ifa.link_up), 256'(p.link));
                    chk("link_up_b", 256'(ifb.link_up), 256'(p.link));
                    chk("frame_cnt_a", 256'(ifa.frame_cnt), 256'(p.fcnt));
                    chk("in_slots_c", 256'(ifc.in_slots), 256'(p.slots[79:0]));
                    chk("in_valid_c", 256'(ifc.in_valid), 256'(p.valid[3:0]));
                    chk("frame_cnt_c", 256'(ifc.frame_cnt), 256'(p.fcnt));
                end
            end
        end
    end

    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tb_pos != pos && n < 400);
        if (tb_pos != pos) chk("align_timeout", 256'(tb_pos), 256'(pos));
    endtask

    // Drive one frame at its strobe cycle, queue expectations, disturb inputs at bit 100.
    task automatic frame(input logic [11:0] ov, input logic [239:0] os, input logic rdy,
                         input logic [11:0] rv, input logic [239:0] rd);
        tx_t  t;
        pub_t p;
        wait_pos(0);
        ifa.out_slots = os;        ifa.out_valid = ov;
        ifb.out_slots = os;        ifb.out_valid = ov;
        ifc.out_slots = os[79:0];  ifc.out_valid = ov[3:0];
        rx_cur = frame_bits(rv, rd, 12, rdy);
        t.frame = tb_frame;
        t.a = frame_bits(ov, zero_invalid(ov, os), 12, 1'b1);
        t.b = m_link ? t.a : IdleTag;
        t.c = frame_bits(ov, zero_invalid(ov, os), 4, 1'b1);
        tx_q.push_back(t);
        if (rdy) begin
            if (m_rdy < 4) m_rdy++;
        end else begin
            m_rdy = 0;
        end
        m_link = (m_rdy == 4);
        m_fcnt = m_fcnt + 16'd1;
        p.frame = tb_frame;
        p.slots = rd;
        p.valid = rv;
        p.rdy   = rdy;
        p.link  = m_link;
        p.fcnt  = m_fcnt;
        pub_q.push_back(p);
        wait_pos(100);
        ifa.out_slots = ~os;        ifa.out_valid = ~ov;
        ifb.out_slots = ~os;        ifb.out_valid = ~ov;
        ifc.out_slots = ~os[79:0];  ifc.out_valid = ~ov[3:0];
    endtask

    initial begin
        logic [239:0] s, d;
        ifa.out_slots = '0; ifa.out_valid = '0;
        ifb.out_slots = '0; ifb.out_valid = '0;
        ifc.out_slots = '0; ifc.out_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sync", 256'(sync_a), 256'(0));
        chk("rst_sdata_out", 256'(sdo_a), 256'(0));
        chk("rst_strobe", 256'(stb_a), 256'(0));
        chk("rst_link_up", 256'(ifb.link_up), 256'(0));
        chk("rst_frame_cnt", 256'(ifa.frame_cnt), 256'(0));
        chk("rst_reset_b", 256'(rstb_a), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #2 chk("reset_b_released", 256'(rstb_c), 256'(1));

        // Slots 3,4 valid with MSB-only data; codec returns ready + slot 3 = 0x12345.
        s = '0; s[40 +: 20] = 20'h80000; s[60 +: 20] = 20'h80000;
        d = '0; d[40 +: 20] = 20'h12345;
        frame(12'h00C, s, 1'b1, 12'h004, d);

        // Ready in frames 0..4, not in 5, ready again 6..10.
        for (int i = 1; i <= 10; i++) begin
            frame(12'($urandom), rnd240(), (i != 5), 12'($urandom), rnd240());
        end

        // Abandon frame 11 at bit 100.
        frame(12'hFFF, rnd240(), 1'b1, 12'hFFF, rnd240());
        rst = 1'b1;
        tx_q.delete();
        pub_q.delete();
        m_rdy = 0; m_link = 1'b0; m_fcnt = '0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_slots", 256'(ifa.in_slots), 256'(0));
        chk("midrst_in_valid", 256'(ifa.in_valid), 256'(0));
        chk("midrst_in_ready", 256'(ifa.in_codec_ready), 256'(0));
        chk("midrst_link_up", 256'(ifa.link_up), 256'(0));
        chk("midrst_frame_cnt", 256'(ifa.frame_cnt), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // 4-slot instance: all valid offered; codec also marks slots 5..8 with data.
        frame(12'hFFF, rnd240(), 1'b1, 12'h0FF, rnd240());
        chk("no_pub_frame_cnt", 256'(ifa.frame_cnt), 256'(0));
        chk("no_pub_in_valid_c", 256'(ifc.in_valid), 256'(0));
        frame(12'h0F3, rnd240(), 1'b1, 12'h02F, rnd240());

        repeat (170) @(posedge clk);
        @(negedge clk);
        chk("tx_queue_drained", 256'(tx_q.size()), 256'(0));
        chk("pub_queue_drained", 256'(pub_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
